linterp_ramp: RTL and testbench
===============================

Name: linterp_ramp

Overview:
- Downstream of the bank-load latch stage. Consumes the parallel Nfft-sample bank (real/imag) that the latch stage updates once per IFFT burst.
- Produces a serial, first-order (linear) interpolated stream. It ramps each bin from the previous bank's value to the current bank's value over Lsteps output steps.
- Output is a valid/ready stream feeding the upsampled DSP chain.

Parameters:
- dwidth, 16, sample width per real/imag component, two's complement.
- Nfft, 32, bins per bank.
- iwidth, $clog2(Nfft), bin index width.
- Lsteps, 16, interpolation steps per bank; must be a power of 2, ≥2.
- lwidth, $clog2(Lsteps), step index width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- bank_dv  in  1  one-cycle strobe: bank_real/bank_imag hold a new bank this cycle.
- bank_real  in  [Nfft-1:0][dwidth-1:0]  bank, real parts.
- bank_imag  in  [Nfft-1:0][dwidth-1:0]  bank, imaginary parts.
- dout_valid  out  1  output sample valid.
- dout_ready  in  1  downstream accepts when high with dout_valid.
- dout_real  out  dwidth  interpolated real sample.
- dout_imag  out  dwidth  interpolated imag sample.
- bin_out  out  iwidth  bin index of current sample.
- step_out  out  lwidth  step index k of current sample.
- overflow  out  1  sticky: a bank was dropped; cleared only by reset.

Behaviour:
- Storage: prev, cur, pend banks (Nfft x real/imag each), plus pend_full flag.
- Reset (async, rst_n=0): all outputs 0; prev=cur=pend=0; pend_full=0; state=IDLE; bin=step=0.
- Order: k outer (0..Lsteps-1), bin inner (0..Nfft-1). Nfft*Lsteps samples per bank.
- Arithmetic, per component:
  - diff = cur - prev, signed dwidth+1.
  - prod = diff * k, k unsigned; full-width result.
  - out = prev + (prod >>> lwidth): arithmetic shift, i.e. floor; no rounding.
  - The result always lies between prev and cur, so no saturation is needed. Truncate to dwidth.
- FSM, states IDLE and RUN:
  - IDLE + bank_dv: cur <= bank; go to RUN with k=0, bin=0.
  - First dout_valid is asserted 2 cycles after the bank_dv cycle (1 cycle to load cur, 1 output register).
  - RUN: dout_* and bin_out/step_out are registered and hold stable while dout_valid && !dout_ready.
  - The next sample is loaded on the handshake cycle, so full throughput of 1 sample/clk with dout_ready held high.
  - Last sample handshaken (k=Lsteps-1, bin=Nfft-1): prev <= cur.
    - If pend_full: cur <= pend, pend_full <= 0, stay in RUN, and the next sample (k=0) follows with no bubble.
    - Else: dout_valid <= 0, go to IDLE.
- bank_dv while in RUN:
  - pend_full=0: pend <= bank, pend_full <= 1.
  - pend_full=1: drop the new bank, set overflow; pend is unchanged.
- bank_dv on the same cycle pend is consumed (end of ramp): the new bank goes to pend and pend_full stays 1. No drop.
- Continuity: the first sample of a ramp equals prev, which is the previous ramp's endpoint bank. The ramp end value cur is not emitted until the next ramp's k=0.
- Reset mid-operation: everything returns to reset values immediately. The in-flight ramp, pend and overflow are discarded.
- bank_dv is ignored while rst_n=0.

Decomposition:
- Package linterp_pkg holds:
  - typedef cplx_t (real/imag, dwidth).
  - typedef bank_t (array [Nfft] of cplx_t).
  - the state enum {IDLE, RUN}.
- One sub-module, linterp_lerp: a combinational single-sample lerp (prev, cur, k -> out) per component. It is instantiated twice (real, imag) after the bin mux.

Test Plan (Nfft=4, Lsteps=4 bench build unless noted):
- After reset, bank A = 400 (real) / -400 (imag) on all bins, dout_ready=1 -> dout_valid rises 2 cycles later.
  - Real per k: 0,100,200,300 (each value repeated across bins 0..3).
  - Imag: 0,-100,-200,-300.
  - 16 samples on consecutive cycles, then dout_valid=0.
- Bank A, then bank B = 0 sent during ramp A -> ramp B follows with no gap: real 400,300,200,100; imag -400,-300,-200,-100.
- Rounding: prev=0, cur real=-1, imag=+1 -> k=1..3 gives real -1,-1,-1 and imag 0,0,0 (floor).
- Backpressure: toggle dout_ready 1010... -> every sample in order and none lost; outputs stable while not ready; 32 cycles for 16 samples.
- Three banks A, B, C within ramp A -> B queued, C dropped, overflow=1 and stays 1; ramp after A is B.
- rst_n low mid-ramp A at k=2 -> dout_valid=0, overflow=0 asynchronously. Next bank D ramps from 0 (prev cleared).

Source files
------------

// File: rtl/linterp_pkg.sv
// Shared types for the bank linear-interpolation ramp: complex sample, bank
// container and the ramp controller state.
package linterp_pkg;

  localparam int DWIDTH = 16;
  localparam int NFFT   = 32;

  typedef struct packed {
    logic signed [DWIDTH-1:0] re;
    logic signed [DWIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t bank_t [NFFT];

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/linterp_lerp.sv
// Single-component linear interpolation: out = prev + floor((cur - prev) * k / 2^lwidth).
module linterp_lerp #(
  parameter int dwidth = 16,
  parameter int lwidth = 4
) (
  input  logic signed [dwidth-1:0] prev_i,
  input  logic signed [dwidth-1:0] cur_i,
  input  logic        [lwidth-1:0] k_i,
  output logic signed [dwidth-1:0] out_o
);

  localparam int PW = dwidth + lwidth + 2;

  logic signed [dwidth:0] diff;
  logic signed [PW-1:0]   prod;

  // The shifted product never leaves [min(prev,cur), max(prev,cur)], so the
  // low dwidth bits of the sum are the exact result.
  always_comb begin
    diff  = {cur_i[dwidth-1], cur_i} - {prev_i[dwidth-1], prev_i};
    prod  = $signed({{(PW-dwidth-1){diff[dwidth]}}, diff}) *
            $signed({{(PW-lwidth){1'b0}}, k_i});
    out_o = prev_i + dwidth'(prod >>> lwidth);
  end

endmodule

// File: rtl/linterp_ramp.sv
// Ramps every bin from the previous bank to the current bank over Lsteps
// output steps, emitted serially (step outer, bin inner) on a valid/ready stream.
module linterp_ramp
  import linterp_pkg::*;
#(
  parameter  int dwidth = DWIDTH,
  parameter  int Nfft   = NFFT,
  parameter  int Lsteps = 16,
  localparam int iwidth = $clog2(Nfft),
  localparam int lwidth = $clog2(Lsteps)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bank_dv,
  input  logic [Nfft-1:0][dwidth-1:0]   bank_real,
  input  logic [Nfft-1:0][dwidth-1:0]   bank_imag,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic signed [dwidth-1:0]      dout_real,
  output logic signed [dwidth-1:0]      dout_imag,
  output logic [iwidth-1:0]             bin_out,
  output logic [lwidth-1:0]             step_out,
  output logic                          overflow
);

  typedef struct packed {
    logic signed [dwidth-1:0] re;
    logic signed [dwidth-1:0] im;
  } samp_t;

  state_t                   state_q, state_d;
  samp_t                    prev_q [Nfft];
  samp_t                    prev_d [Nfft];
  samp_t                    cur_q  [Nfft];
  samp_t                    cur_d  [Nfft];
  samp_t                    pend_q [Nfft];
  samp_t                    pend_d [Nfft];
  samp_t                    bank_in [Nfft];
  logic                     pend_full_q, pend_full_d;
  logic                     overflow_q, overflow_d;
  logic                     done_q, done_d;
  logic                     vld_q, vld_d;
  logic [iwidth-1:0]        bin_q, bin_d, obin_q, obin_d;
  logic [lwidth-1:0]        k_q, k_d, ostep_q, ostep_d;
  logic signed [dwidth-1:0] ore_q, ore_d, oim_q, oim_d;
  samp_t                    lerp_prev, lerp_cur;
  logic signed [dwidth-1:0] lerp_re, lerp_im;
  logic                     fire, ramp_end;

  always_comb begin
    for (int i = 0; i < Nfft; i++) begin
      bank_in[i] = {bank_real[i], bank_imag[i]};
    end
  end

  // Once the last sample of a ramp is loaded (done_q), the operands already
  // look ahead to the queued ramp so its k=0 sample follows without a bubble.
  always_comb begin
    lerp_prev = done_q ? cur_q[bin_q]  : prev_q[bin_q];
    lerp_cur  = done_q ? pend_q[bin_q] : cur_q[bin_q];
  end

  linterp_lerp #(.dwidth(dwidth), .lwidth(lwidth)) u_lerp_re (
    .prev_i (lerp_prev.re),
    .cur_i  (lerp_cur.re),
    .k_i    (k_q),
    .out_o  (lerp_re)
  );

  linterp_lerp #(.dwidth(dwidth), .lwidth(lwidth)) u_lerp_im (
    .prev_i (lerp_prev.im),
    .cur_i  (lerp_cur.im),
    .k_i    (k_q),
    .out_o  (lerp_im)
  );

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    vld_d       = vld_q;
    bin_d       = bin_q;
    k_d         = k_q;
    obin_d      = obin_q;
    ostep_d     = ostep_q;
    ore_d       = ore_q;
    oim_d       = oim_q;
    fire        = 1'b0;
    ramp_end    = 1'b0;

    if (state_q == RUN) begin
      if (!done_q) begin
        fire = !vld_q || dout_ready;
      end else if (vld_q && dout_ready) begin
        ramp_end = 1'b1;
        fire     = pend_full_q;
      end
    end

    if (fire) begin
      ore_d   = lerp_re;
      oim_d   = lerp_im;
      obin_d  = bin_q;
      ostep_d = k_q;
      vld_d   = 1'b1;
      done_d  = 1'b0;
      if (bin_q == iwidth'(Nfft-1)) begin
        bin_d = '0;
        k_d   = k_q + 1'b1;
        if (k_q == lwidth'(Lsteps-1)) done_d = 1'b1;
      end else begin
        bin_d = bin_q + 1'b1;
      end
    end

    if (ramp_end) begin
      prev_d = cur_q;
      if (pend_full_q) begin
        cur_d       = pend_q;
        pend_full_d = 1'b0;
      end else begin
        vld_d  = 1'b0;
        done_d = 1'b0;
        if (bank_dv) cur_d = bank_in;
        else         state_d = IDLE;
      end
    end

    if (bank_dv) begin
      if (state_q == IDLE) begin
        cur_d   = bank_in;
        state_d = RUN;
        bin_d   = '0;
        k_d     = '0;
        done_d  = 1'b0;
      end else if (ramp_end && !pend_full_q) begin
        // new bank already started directly into cur above
      end else if (!pend_full_q || ramp_end) begin
        pend_d      = bank_in;
        pend_full_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      bin_q       <= '0;
      k_q         <= '0;
      obin_q      <= '0;
      ostep_q     <= '0;
      ore_q       <= '0;
      oim_q       <= '0;
      for (int i = 0; i < Nfft; i++) begin
        prev_q[i] <= '0;
        cur_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      bin_q       <= bin_d;
      k_q         <= k_d;
      obin_q      <= obin_d;
      ostep_q     <= ostep_d;
      ore_q       <= ore_d;
      oim_q       <= oim_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
    end
  end

  assign dout_valid = vld_q;
  assign dout_real  = ore_q;
  assign dout_imag  = oim_q;
  assign bin_out    = obin_q;
  assign step_out   = ostep_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_linterp_ramp.sv
// Bench for linterp_ramp built with Nfft=4, Lsteps=4: directed ramp tables,
// queueing/overflow/reset sequences and a randomized run against a floor-division model.
module tb_linterp_ramp;

  localparam int NF = 4;
  localparam int LS = 4;
  localparam int NS = NF * LS;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  bank_dv;
  logic [NF-1:0][15:0]   bank_real;
  logic [NF-1:0][15:0]   bank_imag;
  logic                  dout_valid;
  logic                  dout_ready;
  logic signed [15:0]    dout_real;
  logic signed [15:0]    dout_imag;
  logic [1:0]            bin_out;
  logic [1:0]            step_out;
  logic                  overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int re;
    int im;
    int bin;
    int k;
  } smp_t;

  typedef struct {
    int cre;
    int cim;
    int ere[4];
    int eim[4];
  } vec_t;

  smp_t expq[$];

  linterp_ramp #(.dwidth(16), .Nfft(NF), .Lsteps(LS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_dv    (bank_dv),
    .bank_real  (bank_real),
    .bank_imag  (bank_imag),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .bin_out    (bin_out),
    .step_out   (step_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int pick();
    logic [15:0] r;
    int m;
    m = $urandom_range(0, 4);
    if (m == 0) return 32767;
    if (m == 1) return -32768;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    bank_dv    = 1'b0;
    dout_ready = 1'b0;
    bank_real  = '0;
    bank_imag  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Strobe a uniform bank for one clock; returns on the negedge after capture.
  task automatic send_bank(input int re, input int im);
    bank_dv = 1'b1;
    for (int b = 0; b < NF; b++) begin
      bank_real[b] = 16'(re);
      bank_imag[b] = 16'(im);
    end
    @(negedge clk);
    bank_dv = 1'b0;
  endtask

  // Expects NS samples on consecutive cycles with dout_ready held high.
  task automatic expect_ramp(input string nm, input int vre[4], input int vim[4]);
    for (int k = 0; k < LS; k++) begin
      for (int b = 0; b < NF; b++) begin
        chk({nm, "_valid"}, dout_valid, 1);
        chk({nm, "_re"},    dout_real,  vre[k]);
        chk({nm, "_im"},    dout_imag,  vim[k]);
        chk({nm, "_bin"},   bin_out,    b);
        chk({nm, "_step"},  step_out,   k);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vec_t tbl[3];
    int   er[4];
    int   ei[4];
    int   n, vc, found;
    logic pv, pr;
    int   sre, sbin, sstep;
    int   mprev_re[NF], mprev_im[NF], nb_re[NF], nb_im[NF];
    int   dropped;
    smp_t e;

    tbl[0] = '{cre: 400,    cim: -400,   ere: '{0, 100, 200, 300},        eim: '{0, -100, -200, -300}};
    tbl[1] = '{cre: -1,     cim: 1,      ere: '{0, -1, -1, -1},           eim: '{0, 0, 0, 0}};
    tbl[2] = '{cre: 32767,  cim: -32768, ere: '{0, 8191, 16383, 24575},   eim: '{0, -8192, -16384, -24576}};

    // Reset values observed while rst_n is still low
    rst_n = 1'b0; bank_dv = 1'b0; dout_ready = 1'b1; bank_real = '0; bank_imag = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ovf",   overflow,   0);
    chk("rst_re",    dout_real,  0);
    chk("rst_im",    dout_imag,  0);
    chk("rst_bin",   bin_out,    0);
    chk("rst_step",  step_out,   0);

    // Table-driven single ramps from a cleared prev bank
    for (int t = 0; t < 3; t++) begin
      do_reset();
      dout_ready = 1'b1;
      send_bank(tbl[t].cre, tbl[t].cim);
      chk("tbl_lat1", dout_valid, 0);
      @(negedge clk);
      er = tbl[t].ere;
      ei = tbl[t].eim;
      expect_ramp($sformatf("tbl%0d", t), er, ei);
      chk("tbl_end_valid", dout_valid, 0);
    end

    // A then B queued: gapless second ramp from A down to B
    do_reset();
    dout_ready = 1'b1;
    send_bank(400, -400);
    send_bank(0, 0);
    er = '{0, 100, 200, 300};   ei = '{0, -100, -200, -300};
    expect_ramp("ab_a", er, ei);
    er = '{400, 300, 200, 100}; ei = '{-400, -300, -200, -100};
    expect_ramp("ab_b", er, ei);
    chk("ab_end_valid", dout_valid, 0);
    chk("ab_ovf", overflow, 0);

    // Backpressure: ready alternates, first valid cycle stalled
    do_reset();
    dout_ready = 1'b1;
    send_bank(400, -400);
    n = 0; vc = 0; pv = 1'b0; pr = 1'b0; sre = 0; sbin = 0; sstep = 0;
    for (int i = 0; i < 80 && n < NS; i++) begin
      dout_ready = (i % 2 == 0);
      #1;
      if (dout_valid) vc++;
      if (dout_valid && pv && !pr) begin
        chk("bp_hold_re",   dout_real, sre);
        chk("bp_hold_bin",  bin_out,   sbin);
        chk("bp_hold_step", step_out,  sstep);
      end
      if (dout_valid && dout_ready) begin
        chk("bp_re",   dout_real, 100 * (n / NF));
        chk("bp_im",   dout_imag, -100 * (n / NF));
        chk("bp_bin",  bin_out,   n % NF);
        chk("bp_step", step_out,  n / NF);
        n++;
      end
      pv = dout_valid; pr = dout_ready;
      sre = dout_real; sbin = bin_out; sstep = step_out;
      @(negedge clk);
    end
    chk("bp_count",  n,  NS);
    chk("bp_cycles", vc, 2 * NS);
    chk("bp_end_valid", dout_valid, 0);

    // A, B, C during ramp A: B queued, C dropped
    do_reset();
    dout_ready = 1'b0;
    send_bank(400, -400);
    send_bank(0, 0);
    send_bank(-1000, 1000);
    chk("ov_flag_early", overflow, 1);
    dout_ready = 1'b1;
    er = '{0, 100, 200, 300};   ei = '{0, -100, -200, -300};
    expect_ramp("ov_a", er, ei);
    er = '{400, 300, 200, 100}; ei = '{-400, -300, -200, -100};
    expect_ramp("ov_b", er, ei);
    chk("ov_end_valid", dout_valid, 0);
    repeat (3) @(negedge clk);
    chk("ov_no_c", dout_valid, 0);
    chk("ov_sticky", overflow, 1);

    // Asynchronous reset in the middle of ramp A at k=2
    do_reset();
    dout_ready = 1'b1;
    send_bank(400, -400);
    send_bank(0, 0);
    send_bank(-1000, 1000);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (step_out == 2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mr_reach_k2", found, 1);
    chk("mr_ovf_before", overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", dout_valid, 0);
    chk("mr_ovf",   overflow,   0);
    chk("mr_re",    dout_real,  0);
    bank_dv = 1'b1;
    for (int b = 0; b < NF; b++) begin
      bank_real[b] = 16'(5000);
      bank_imag[b] = 16'(5000);
    end
    @(negedge clk);
    bank_dv = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_dv_ignored", dout_valid, 0);
    send_bank(200, -200);
    @(negedge clk);
    er = '{0, 50, 100, 150}; ei = '{0, -50, -100, -150};
    expect_ramp("mr_d", er, ei);
    chk("mr_end_valid", dout_valid, 0);

    // Randomized banks and backpressure against the model
    do_reset();
    for (int b = 0; b < NF; b++) begin
      mprev_re[b] = 0;
      mprev_im[b] = 0;
    end
    dropped = 0;
    for (int c = 0; c < 3000; c++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      bank_dv    = ($urandom_range(0, 24) == 0);
      if (bank_dv) begin
        for (int b = 0; b < NF; b++) begin
          nb_re[b] = pick();
          nb_im[b] = pick();
          bank_real[b] = 16'(nb_re[b]);
          bank_imag[b] = 16'(nb_im[b]);
        end
      end
      #1;
      if (dout_valid && dout_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL rnd_extra: got sample re=%0d bin=%0d expected none", dout_real, bin_out);
        end else begin
          e = expq.pop_front();
          chk("rnd_re",   dout_real, e.re);
          chk("rnd_im",   dout_imag, e.im);
          chk("rnd_bin",  bin_out,   e.bin);
          chk("rnd_step", step_out,  e.k);
        end
      end
      if (bank_dv) begin
        if ((expq.size() + NS - 1) / NS < 2) begin
          for (int k = 0; k < LS; k++) begin
            for (int b = 0; b < NF; b++) begin
              e.re  = mprev_re[b] + fdiv((nb_re[b] - mprev_re[b]) * k, LS);
              e.im  = mprev_im[b] + fdiv((nb_im[b] - mprev_im[b]) * k, LS);
              e.bin = b;
              e.k   = k;
              expq.push_back(e);
            end
          end
          mprev_re = nb_re;
          mprev_im = nb_im;
        end else begin
          dropped = 1;
        end
      end
      @(negedge clk);
    end
    bank_dv    = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (expq.size() == 0 && !dout_valid) break;
      if (dout_valid) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL rnd_drain_extra: got sample re=%0d expected none", dout_real);
        end else begin
          e = expq.pop_front();
          chk("rnd_drain_re",  dout_real, e.re);
          chk("rnd_drain_im",  dout_imag, e.im);
          chk("rnd_drain_bin", bin_out,   e.bin);
        end
      end
      @(negedge clk);
    end
    chk("rnd_left",  expq.size(), 0);
    chk("rnd_ovf",   overflow,    dropped);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
